// File: rtl/pc_sequencer.sv
// ----------------------------------------------------------------------------
// pc_sequencer
//   Owns the OTTER program counter and issues fetch requests to instruction
//   memory over a valid/ready handshake. PC-update requests from the control
//   unit are applied immediately when the current fetch completes in the same
//   cycle, otherwise they are parked in a one-entry pending register until the
//   handshake happens. Misaligned control-transfer targets vector to mtvec.
//
// Ports:
//   CLK, RST_N      clock; synchronous active-low reset
//   pc_write        request to update the PC this cycle
//   pc_sel          0 pc+4, 1 jalr, 2 branch, 3 jal, 4 mtvec, 5 mepc, 6/7 pc+4
//   jal/branch/jalr candidate control-transfer targets
//   mtvec, mepc     CSR vectors
//   fetch_ready     instruction memory accepts the current pc
//   fetch_valid     pc is a valid fetch address
//   pc, pc_plus4    current program counter and its wrapped successor
//   busy            an update request is pending; pc_write is ignored
//   misalign_trap   one-cycle pulse while the trap is being taken
//   trap_addr       offending target of the most recent trap
// ----------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_ADDR      = 32'h0000_0000,
    parameter bit          MTVEC_ALIGN_CHK = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        pc_write,
    input  logic [2:0]  pc_sel,
    input  logic [31:0] jal,
    input  logic [31:0] branch,
    input  logic [31:0] jalr,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic        fetch_ready,
    output logic        fetch_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        busy,
    output logic        misalign_trap,
    output logic [31:0] trap_addr
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_TRAP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  pend_sel_q, pend_sel_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic [31:0] trap_addr_q, trap_addr_d;

    logic [31:0] sel_tgt;
    logic        sel_bad;
    logic        pend_bad;

    // Only control transfers are alignment-checked; the CSR vectors are
    // checked only when MTVEC_ALIGN_CHK is set, and pc+4 never is.
    function automatic logic is_misaligned(input logic [2:0] sel, input logic [31:0] tgt);
        case (sel)
            3'd1, 3'd2, 3'd3: return tgt[1:0] != 2'b00;
            3'd4, 3'd5:       return MTVEC_ALIGN_CHK && (tgt[1:0] != 2'b00);
            default:          return 1'b0;
        endcase
    endfunction

    assign pc_plus4 = pc_q + 32'd4;

    // Target mux; jalr drops its LSB before the alignment check.
    always_comb begin
        sel_tgt = pc_plus4;
        case (pc_sel)
            3'd1:    sel_tgt = {jalr[31:1], 1'b0};
            3'd2:    sel_tgt = branch;
            3'd3:    sel_tgt = jal;
            3'd4:    sel_tgt = mtvec;
            3'd5:    sel_tgt = mepc;
            default: sel_tgt = pc_plus4;
        endcase
    end

    assign sel_bad  = is_misaligned(pc_sel, sel_tgt);
    assign pend_bad = is_misaligned(pend_sel_q, pend_tgt_q);

    always_comb begin
        // NOTE: every signal written here gets a default first so no path
        // through the case leaves one unassigned and infers a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        pend_sel_d  = pend_sel_q;
        pend_tgt_d  = pend_tgt_q;
        trap_addr_d = trap_addr_q;

        case (state_q)
            ST_BOOT: state_d = ST_ISSUE;

            ST_ISSUE: begin
                if (pc_write) begin
                    if (fetch_ready) begin
                        if (sel_bad) begin
                            state_d     = ST_TRAP;
                            trap_addr_d = sel_tgt;
                        end else begin
                            pc_d = sel_tgt;
                        end
                    end else begin
                        // Fetch stalled: park the request so pc stays stable
                        // and later input changes cannot alter the target.
                        pend_sel_d = pc_sel;
                        pend_tgt_d = sel_tgt;
                        state_d    = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                if (fetch_ready) begin
                    if (pend_bad) begin
                        state_d     = ST_TRAP;
                        trap_addr_d = pend_tgt_q;
                    end else begin
                        pc_d    = pend_tgt_q;
                        state_d = ST_ISSUE;
                    end
                end
            end

            ST_TRAP: begin
                pc_d    = {mtvec[31:2], 2'b00};
                state_d = ST_ISSUE;
            end

            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge CLK) begin
        // NOTE: the pending register is reset along with the control state so
        // a request parked before reset can never be applied afterwards.
        if (!RST_N) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_ADDR;
            pend_sel_q  <= 3'd0;
            pend_tgt_q  <= 32'd0;
            trap_addr_q <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_sel_q  <= pend_sel_d;
            pend_tgt_q  <= pend_tgt_d;
            trap_addr_q <= trap_addr_d;
        end
    end

    assign pc            = pc_q;
    assign fetch_valid   = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign busy          = (state_q == ST_WAIT);
    assign misalign_trap = (state_q == ST_TRAP);
    assign trap_addr     = trap_addr_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed scenarios followed by randomized traffic. A transaction-level
//   reference model (boot/trap flags, a queue of parked requests, a PC value)
//   predicts every output after each clock edge.
// ----------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
    localparam bit          CHK        = 1'b1;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        pc_write;
    logic [2:0]  pc_sel;
    logic [31:0] jal, branch, jalr, mtvec, mepc;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] pc, pc_plus4, trap_addr;
    logic        busy, misalign_trap;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    pc_sequencer #(
        .RESET_ADDR      (RESET_ADDR),
        .MTVEC_ALIGN_CHK (CHK)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .pc_write      (pc_write),
        .pc_sel        (pc_sel),
        .jal           (jal),
        .branch        (branch),
        .jalr          (jalr),
        .mtvec         (mtvec),
        .mepc          (mepc),
        .fetch_ready   (fetch_ready),
        .fetch_valid   (fetch_valid),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .busy          (busy),
        .misalign_trap (misalign_trap),
        .trap_addr     (trap_addr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0]  sel;
        logic [31:0] tgt;
    } req_t;

    logic [31:0] m_pc;
    logic [31:0] m_taddr;
    bit          m_boot;
    bit          m_trap;
    req_t        m_pend[$];

    function automatic req_t make_req();
        req_t r;
        r.sel = pc_sel;
        case (pc_sel)
            3'd1:    r.tgt = jalr & ~32'd1;
            3'd2:    r.tgt = branch;
            3'd3:    r.tgt = jal;
            3'd4:    r.tgt = mtvec;
            3'd5:    r.tgt = mepc;
            default: r.tgt = m_pc + 32'd4;
        endcase
        return r;
    endfunction

    function automatic bit req_bad(input req_t r);
        bit xfer = (r.sel >= 3'd1 && r.sel <= 3'd3) || (CHK && (r.sel == 3'd4 || r.sel == 3'd5));
        return xfer && (r.tgt % 4 != 0);
    endfunction

    task automatic apply(input req_t r);
        if (req_bad(r)) begin
            m_trap  = 1;
            m_taddr = r.tgt;
        end else begin
            m_pc = r.tgt;
        end
    endtask

    // Advance the model by one edge using the inputs currently driven.
    task automatic model_edge();
        if (!RST_N) begin
            m_pc    = RESET_ADDR;
            m_taddr = 32'd0;
            m_boot  = 1;
            m_trap  = 0;
            m_pend.delete();
        end else if (m_boot) begin
            m_boot = 0;
        end else if (m_trap) begin
            m_pc   = mtvec & ~32'd3;
            m_trap = 0;
        end else if (m_pend.size() != 0) begin
            if (fetch_ready) apply(m_pend.pop_front());
        end else if (pc_write) begin
            if (fetch_ready) apply(make_req());
            else m_pend.push_back(make_req());
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
        check("pc",            pc,            m_pc);
        check("pc_plus4",      pc_plus4,      m_pc + 32'd4);
        check("fetch_valid",   32'(fetch_valid),   32'(!m_boot && !m_trap));
        check("busy",          32'(busy),          32'(m_pend.size() != 0));
        check("misalign_trap", 32'(misalign_trap), 32'(m_trap));
        check("trap_addr",     trap_addr,     m_taddr);
    endtask

    task automatic drive(input logic w, input logic [2:0] s, input logic rdy);
        pc_write    = w;
        pc_sel      = s;
        fetch_ready = rdy;
        tick();
    endtask

    function automatic logic [31:0] rand_tgt();
        logic [31:0] v = $urandom;
        if ($urandom_range(0, 1) == 0) v[1:0] = 2'b00;
        return v;
    endfunction

    initial begin
        RST_N = 1'b0; pc_write = 1'b0; pc_sel = 3'd0; fetch_ready = 1'b1;
        jal = 32'd0; branch = 32'd0; jalr = 32'd0; mtvec = 32'h400; mepc = 32'd0;
        m_pc = RESET_ADDR; m_taddr = 32'd0; m_boot = 1; m_trap = 0;

        // Reset, then boot: fetch_valid low one cycle, then sequential fetch.
        #1;
        tick();
        tick();
        check("rst_pc", pc, RESET_ADDR);
        check("rst_fv", 32'(fetch_valid), 32'd0);
        RST_N = 1'b1;
        drive(1'b1, 3'd0, 1'b1);            // pc_write during BOOT is ignored
        check("boot_fv", 32'(fetch_valid), 32'd1);
        check("boot_pc", pc, 32'd0);
        drive(1'b1, 3'd0, 1'b1); check("seq4", pc, 32'd4);
        drive(1'b1, 3'd0, 1'b1); check("seq8", pc, 32'd8);
        drive(1'b1, 3'd0, 1'b1); check("seq12", pc, 32'd12);

        // Stalled branch: target latched, later branch change ignored.
        jal = 32'h100; drive(1'b1, 3'd3, 1'b1); check("jal100", pc, 32'h100);
        branch = 32'h80; drive(1'b1, 3'd2, 1'b0);
        check("wait_busy", 32'(busy), 32'd1);
        check("wait_pc", pc, 32'h100);
        branch = 32'h200; drive(1'b1, 3'd0, 1'b0);
        drive(1'b0, 3'd0, 1'b1);
        check("wait_apply", pc, 32'h80);
        check("wait_busy0", 32'(busy), 32'd0);

        // Misaligned jal traps, then vectors to mtvec.
        jal = 32'h102; mtvec = 32'h400; drive(1'b1, 3'd3, 1'b1);
        check("trap_pulse", 32'(misalign_trap), 32'd1);
        check("trap_addr", trap_addr, 32'h102);
        drive(1'b1, 3'd0, 1'b1);            // ignored during TRAP
        check("trap_vec", pc, 32'h400);
        check("trap_end", 32'(misalign_trap), 32'd0);

        // jalr LSB clearing vs a genuinely misaligned jalr target.
        jalr = 32'h201; drive(1'b1, 3'd1, 1'b1);
        check("jalr_ok", pc, 32'h200);
        check("jalr_notrap", 32'(misalign_trap), 32'd0);
        jalr = 32'h202; drive(1'b1, 3'd1, 1'b1);
        check("jalr_trap", trap_addr, 32'h202);
        drive(1'b0, 3'd0, 1'b1);

        // Wrap of pc+4, then mepc return.
        jal = 32'hFFFF_FFFC; drive(1'b1, 3'd3, 1'b1);
        drive(1'b1, 3'd0, 1'b1);
        check("wrap_pc", pc, 32'd0);
        check("wrap_p4", pc_plus4, 32'd4);
        mepc = 32'h44; drive(1'b1, 3'd5, 1'b1);
        check("mepc", pc, 32'h44);

        // Reset during WAIT discards the parked branch.
        branch = 32'h300; drive(1'b1, 3'd2, 1'b0);
        RST_N = 1'b0; drive(1'b0, 3'd0, 1'b1);
        check("rstw_pc", pc, RESET_ADDR);
        check("rstw_busy", 32'(busy), 32'd0);
        check("rstw_fv", 32'(fetch_valid), 32'd0);
        RST_N = 1'b1;
        for (int i = 0; i < 4; i++) drive(1'b0, 3'd0, 1'b1);
        check("rstw_noapply", pc, RESET_ADDR);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            jal    = rand_tgt();
            branch = rand_tgt();
            jalr   = rand_tgt();
            mtvec  = rand_tgt();
            mepc   = rand_tgt();
            RST_N  = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 9) < 7));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
